multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the multicycle CPU Datapath one instruction at a time.
- It drives every Datapath control input (SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg, BEQ, PCSrc), plus PCWrite and IRWrite.
- It decodes the instruction opcode, stretches memory states by a ready handshake, and flags illegal opcodes.
- It sits between the instruction register and the Datapath, replacing hand-driven control stimulus.

Parameters:
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from the Datapath instruction register; sampled in DECODE
- mem_ready  in  1  memory access complete this cycle
- SelectIns  out  1  1 = memory address from PC (instruction fetch), 0 = from ALU result
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC update
- RegWrite  out  1  register file write enable
- RegDst  out  1  1 = rd, 0 = rt destination
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = reg B, 01 = constant 1, 10 = sign-extended imm, 11 = imm<<0 branch offset
- MemWrite  out  1  data memory write
- MemtoReg  out  1  1 = write-back from memory data, 0 = from ALU result
- BEQ  out  1  conditional PC update, gated by ALU zero inside the Datapath
- PCSrc  out  2  00 = ALU result, 01 = ALU-out branch target, 10 = jump target
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  sticky; set on an undefined opcode
- retired  out  RETIRE_W  count of completed instructions; wraps modulo 2^RETIRE_W

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, illegal=0, retired=0.
  - All outputs take their FETCH-decoded values, except PCWrite and IRWrite, which are forced to 0 while rst_n=0.
- Outputs are a pure function of the registered state (Moore); no output depends combinationally on opcode.
- Defaults: every output is 0 unless listed for the state.
- FETCH: SelectIns=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00.
  - If mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold; IRWrite and PCWrite are 0 (these two are gated by mem_ready).
- DECODE: ALUSrcA=0, ALUSrcB=11 (precompute branch target). Next state by opcode:
  - 000000 -> EXEC_R
  - 001000 -> EXEC_I
  - 100011 -> MEM_ADDR
  - 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other -> HALT
- EXEC_R: ALUSrcA=1, ALUSrcB=00 -> WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10 -> WB_I.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Next is MEM_RD for opcode 100011, MEM_WR for 101011. Opcode must stay stable from DECODE to MEM_ADDR (IR is not rewritten).
- MEM_RD: SelectIns=0. Hold until mem_ready=1, then -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1 -> FETCH.
- MEM_WR: SelectIns=0, MemWrite=1, asserted every cycle while waiting (the memory ignores it until ready). instr_done=mem_ready; on mem_ready=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, BEQ=1, PCSrc=01, instr_done=1 -> FETCH.
- JUMP: PCWrite=1, PCSrc=10, instr_done=1 -> FETCH.
- HALT: all outputs 0, illegal=1. Remain until reset; no further fetches.
- Latency with mem_ready=1 throughout: R-type/ADDI/SW = 4 cycles, LW = 5, BEQ/J = 3.
- retired increments on each cycle where instr_done=1.
- rst_n asserted mid-instruction: abort immediately to FETCH. No partial write completes after the reset edge.

Decomposition:
- Shared package mc_pkg:
  - opcode localparams: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALUSrcB encodings and PCSrc encodings
  - state enum, 4-bit encoding
- Sub-module: none needed. Optionally mc_out_decode, a purely combinational state -> control-word decode, so the FSM and its output table can be reviewed separately.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> PCWrite=0, IRWrite=0, retired=0, illegal=0. On release, the first cycle shows SelectIns=1, ALUSrcB=01, IRWrite=1.
- R-type: opcode=000000, mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R. The 4th cycle has RegWrite=1, RegDst=1, instr_done=1. retired=1.
- LW with wait states: opcode=100011, mem_ready low for 2 cycles in MEM_RD -> total 7 cycles. MEM_WB has MemtoReg=1, RegWrite=1.
- SW then BEQ then J: opcodes 101011, 000100, 000010 with mem_ready=1 -> 4+3+3 = 10 cycles.
  - MemWrite=1 for exactly 1 cycle; BEQ=1 with PCSrc=01 for 1 cycle; PCWrite=1 with PCSrc=10 for 1 cycle.
  - retired=3.
- Illegal opcode: opcode=111111 in DECODE -> HALT, illegal=1, all controls 0 for 20 cycles. rst_n pulse clears illegal and restarts at FETCH.
- Counter wrap with RETIRE_W=4: 17 J instructions -> retired=1. Async reset asserted mid-MEM_WR -> MemWrite drops within the same cycle, state=FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle CPU control FSM: opcodes, mux
// encodings, state encoding and the control-word bundle.
package mc_pkg;

    // Opcodes (instruction[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUSrcB mux select
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    // PCSrc mux select
    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    typedef struct packed {
        logic       sel_ins;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_write;
        logic       mem_to_reg;
        logic       beq;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    // Opcode dispatch out of DECODE; anything unknown parks the machine in HALT
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:      return ST_EXEC_R;
            OP_ADDI:       return ST_EXEC_I;
            OP_LW, OP_SW:  return ST_MEM_ADDR;
            OP_BEQ:        return ST_BRANCH;
            OP_J:          return ST_JUMP;
            default:       return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state -> control-word table. The only non-state input is
// mem_ready, which gates the FETCH write enables and the MEM_WR completion.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    // Output table; every field defaults to 0 and each state lists its ones
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.sel_ins   = 1'b1;
                o_ctrl.alu_src_b = SRCB_ONE;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b = SRCB_BR;
            end
            ST_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            ST_WB_R: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_WB_I: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_MEM_RD: begin
                o_ctrl.sel_ins = 1'b0;
            end
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                // Held high while waiting; the memory commits only on ready
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = SRCB_REG;
                o_ctrl.beq        = 1'b1;
                o_ctrl.pc_src     = PCSRC_BR;
                o_ctrl.instr_done = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_src     = PCSRC_JMP;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/write-back
// one instruction at a time, counts retired instructions and latches illegal
// opcodes.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                SelectIns,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                BEQ,
    output logic [1:0]          PCSrc,
    output logic                instr_done,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_t              r_state;
    state_t              w_next;
    ctrl_t               w_ctrl;
    logic                r_illegal;
    logic [RETIRE_W-1:0] r_retired;

    mc_out_decode u_out_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Next-state logic; opcode is only consulted in DECODE and MEM_ADDR
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:    if (mem_ready) w_next = ST_DECODE;
            ST_DECODE:   w_next = decode_next(opcode);
            ST_EXEC_R:   w_next = ST_WB_R;
            ST_EXEC_I:   w_next = ST_WB_I;
            ST_MEM_ADDR: w_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) w_next = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready) w_next = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_MEM_WB, ST_BRANCH, ST_JUMP: w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            default:     w_next = ST_FETCH;
        endcase
    end

    // State, sticky illegal flag and wrapping retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_HALT)
                r_illegal <= 1'b1;
            if (w_ctrl.instr_done)
                r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    // While reset is held the state already reads FETCH; only the two
    // write enables need an extra gate so nothing is loaded during reset.
    assign SelectIns  = w_ctrl.sel_ins;
    assign IRWrite    = w_ctrl.ir_write & rst_n;
    assign PCWrite    = w_ctrl.pc_write & rst_n;
    assign RegWrite   = w_ctrl.reg_write;
    assign RegDst     = w_ctrl.reg_dst;
    assign ALUSrcA    = w_ctrl.alu_src_a;
    assign ALUSrcB    = w_ctrl.alu_src_b;
    assign MemWrite   = w_ctrl.mem_write;
    assign MemtoReg   = w_ctrl.mem_to_reg;
    assign BEQ        = w_ctrl.beq;
    assign PCSrc      = w_ctrl.pc_src;
    assign instr_done = w_ctrl.instr_done;
    assign illegal    = r_illegal;
    assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each issued instruction pushes its
// expected completion record; a monitor pops one on every instr_done.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          SelectIns, IRWrite, PCWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0]    ALUSrcB, PCSrc;
    logic          MemWrite, MemtoReg, BEQ, instr_done, illegal;
    logic [RW-1:0] retired;

    multicycle_ctrl #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .SelectIns(SelectIns), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .BEQ(BEQ), .PCSrc(PCSrc), .instr_done(instr_done),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        logic       rw, rd, m2r, mw, beq, pcw;
        logic [1:0] pcsrc;
        logic [2:0] c3;     // {ALUSrcA, ALUSrcB} expected in the third cycle
        int         ret;
    } exp_t;

    exp_t sbq[$];
    int   npass = 0;
    int   ntot  = 0;
    int   mret  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Hand-written completion-cycle table per instruction class
    function automatic exp_t mk(input logic [5:0] op, input int lat);
        exp_t e;
        e = '{lat: lat, rw: 0, rd: 0, m2r: 0, mw: 0, beq: 0, pcw: 0,
              pcsrc: 2'b00, c3: 3'b000, ret: 0};
        case (op)
            OP_RTYPE: begin e.rw = 1; e.rd = 1; e.c3 = 3'b100; end
            OP_ADDI:  begin e.rw = 1; e.c3 = 3'b110; end
            OP_LW:    begin e.rw = 1; e.m2r = 1; e.c3 = 3'b110; end
            OP_SW:    begin e.mw = 1; e.c3 = 3'b110; end
            OP_BEQ:   begin e.beq = 1; e.pcsrc = 2'b01; e.c3 = 3'b100; end
            OP_J:     begin e.pcw = 1; e.pcsrc = 2'b10; e.c3 = 3'b000; end
            default:  e.lat = 0;
        endcase
        return e;
    endfunction

    // Monitor: count cycles between completions and check each completion
    initial begin
        int   cnt;
        exp_t e;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) cnt = 0;
            else begin
                cnt++;
                if (instr_done) begin
                    if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                    else begin
                        e = sbq.pop_front();
                        chk("latency", cnt, e.lat);
                        chk("done_ctrl",
                            32'({RegWrite, RegDst, MemtoReg, MemWrite, BEQ, PCWrite, PCSrc}),
                            32'({e.rw, e.rd, e.m2r, e.mw, e.beq, e.pcw, e.pcsrc}));
                        chk("done_retired", 32'(retired), e.ret);
                    end
                    cnt = 0;
                end
            end
        end
    end

    // Run one instruction for lat cycles; mem_ready low for wn cycles from ws
    task automatic run(input logic [5:0] op, input int lat, input int ws, input int wn,
                       input bit push, output int nmw, output int nbeq, output int njmp);
        exp_t e;
        e = mk(op, lat);
        if (push) begin
            e.ret = mret;
            sbq.push_back(e);
            mret = (mret + 1) % (1 << RW);
        end
        nmw = 0; nbeq = 0; njmp = 0;
        opcode = op;
        for (int c = 1; c <= lat; c++) begin
            mem_ready = !(c >= ws && c < ws + wn);
            @(negedge clk);
            if (c == 1 && ws != 1)
                chk("fetch_ctrl", 32'({SelectIns, IRWrite, PCWrite, ALUSrcA, ALUSrcB, PCSrc}),
                    32'({1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00}));
            if (c == 2)
                chk("decode_ctrl", 32'({SelectIns, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB}),
                    32'({5'b00000, 1'b0, 2'b11}));
            if (c == 3)
                chk("cycle3_src", 32'({SelectIns, ALUSrcA, ALUSrcB}), 32'({1'b0, e.c3}));
            if (MemWrite) nmw++;
            if (BEQ && PCSrc == 2'b01) nbeq++;
            if (PCWrite && PCSrc == 2'b10) njmp++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mw, nb, nj, bad;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_we", 32'({PCWrite, IRWrite}), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_fetch_ctrl", 32'({SelectIns, ALUSrcB}), 32'b101);
        rst_n = 1'b1;

        run(OP_RTYPE, 4, 0, 0, 1, mw, nb, nj);
        chk("retired_after_r", 32'(retired), 32'd1);
        run(OP_ADDI, 4, 0, 0, 1, mw, nb, nj);
        run(OP_LW, 7, 4, 2, 1, mw, nb, nj);
        chk("lw_memwrite", mw, 0);
        run(OP_SW, 4, 0, 0, 1, mw, nb, nj);
        chk("sw_memwrite_cycles", mw, 1);
        run(OP_BEQ, 3, 0, 0, 1, mw, nb, nj);
        chk("beq_cycles", nb, 1);
        run(OP_J, 3, 0, 0, 1, mw, nb, nj);
        chk("jump_cycles", nj, 1);
        chk("retired_after_six", 32'(retired), 32'd6);

        // Illegal opcode: two cycles to reach HALT, then stay silent
        opcode = 6'b111111; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({SelectIns, IRWrite, PCWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB,
                 MemWrite, MemtoReg, BEQ, PCSrc, instr_done} != 14'd0 || illegal !== 1'b1)
                bad++;
        end
        chk("halt_quiet_cycles", bad, 0);
        chk("halt_illegal", 32'(illegal), 32'd1);
        chk("halt_no_retire", 32'(retired), 32'd6);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_clears_illegal", 32'(illegal), 32'd0);
        chk("rst_clears_retired", 32'(retired), 32'd0);
        chk("rst_gates_irwrite", 32'({IRWrite, PCWrite, SelectIns}), 32'b001);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mret = 0;

        // Retire counter wrap: 17 jumps on a 4-bit counter
        repeat (17) run(OP_J, 3, 0, 0, 1, mw, nb, nj);
        chk("retired_wrap", 32'(retired), 32'd1);

        // Abort a store that is stalled in MEM_WR
        run(OP_SW, 4, 4, 1, 0, mw, nb, nj);
        @(negedge clk);
        chk("memwr_waiting", 32'({MemWrite, SelectIns}), 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_memwrite", 32'({MemWrite, SelectIns, ALUSrcB}), 32'b0101);
        chk("abort_retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
